conv_kx1_stream: RTL and testbench



---
 rtl/conv_kx1_stream.sv | 193 +++++++++++++++++++
 tb/tb_conv_kx1_stream.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kx1_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv_kx1_stream
// Description : Vertical Kx1 convolution over a raster pixel stream. Keeps
//               K-1 line buffers indexed by column, applies runtime signed
//               coefficients latched at the start of each frame, rounds,
//               shifts and saturates, and flags the last output of a frame.
// Ports       : clk         rising-edge clock
//               reset       asynchronous active-low reset
//               pxl_in      input pixel (raster order), pxl_in_vld qualifies it
//               coef        K packed signed taps, tap j at [j*CW +: CW]
//               pad_mode    0 = rows >= K-1 only, 1 = zero-padded top border
//               pxl_out     filtered pixel, qualified by valid
//               frame_done  pulse with the valid of the last frame pixel
// Revision    : 1.0 - initial release
// ============================================================================
module conv_kx1_stream #(
    parameter int IMG_W = 220,
    parameter int IMG_H = 220,
    parameter int K     = 7,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int SHIFT = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   pxl_in,
    input  logic            pxl_in_vld,
    input  logic [K*CW-1:0] coef,
    input  logic            pad_mode,
    output logic [DW-1:0]   pxl_out,
    output logic            valid,
    output logic            frame_done
);
    localparam int COLW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROWW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW   = DW + CW + 1;
    localparam int AW   = DW + CW + $clog2(K) + 1;

    localparam logic [COLW-1:0]      COL_LAST = COLW'(IMG_W - 1);
    localparam logic [ROWW-1:0]      ROW_LAST = ROWW'(IMG_H - 1);
    localparam logic [ROWW-1:0]      ROW_RUN  = ROWW'(K - 1);
    localparam logic signed [AW-1:0] RND      = AW'(1 << (SHIFT - 1));
    localparam logic signed [AW-1:0] MAXV     = AW'((1 << DW) - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [COLW-1:0]   col;
    logic [ROWW-1:0]   row;
    logic              accept, frame_start, col_last, frame_last;
    logic              enter_run, emit;
    logic [K*CW-1:0]   coef_q, coef_eff;
    logic              pad_q, pad_eff;

    // lbuf[i][c] holds the pixel at (row-1-i, c) relative to the current row.
    logic [DW-1:0]         lbuf [K-1][IMG_W];
    logic [DW-1:0]         tap  [K];
    logic signed [PW-1:0]  prod [K];
    logic signed [AW-1:0]  acc, res;
    logic [DW-1:0]         sat;
    logic                  v1, fd1;

    assign accept      = pxl_in_vld;
    assign col_last    = (col == COL_LAST);
    assign frame_last  = col_last && (row == ROW_LAST);
    assign frame_start = (row == '0) && (col == '0);

    // Configuration is captured on the first pixel of a frame; that pixel
    // itself must already see the new values, hence the bypass.
    assign coef_eff = frame_start ? coef : coef_q;
    assign pad_eff  = frame_start ? pad_mode : pad_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col    <= '0;
            row    <= '0;
            coef_q <= '0;
            pad_q  <= 1'b0;
        end else if (accept) begin
            if (frame_start) begin
                coef_q <= coef;
                pad_q  <= pad_mode;
            end
            if (col_last) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        enter_run = 1'b0;
        case (state)
            FILL: begin
                if (accept && (row == ROW_RUN) && (col == '0)) begin
                    state_nxt = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (accept && frame_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // The first pixel of row K-1 is accepted while still in FILL, so the
    // transition itself must already enable output.
    assign emit = pad_eff || (state == RUN) || enter_run;

    // Line buffers are a column-indexed shift: every accepted pixel pushes
    // the column's history one line deeper. No reset; rows above the frame
    // top are masked by the row counter instead of being cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][col] <= pxl_in;
            for (int i = 1; i < K - 1; i++) begin
                lbuf[i][col] <= lbuf[i-1][col];
            end
        end
    end

    always_comb begin
        tap[0] = pxl_in;
        for (int j = 1; j < K; j++) begin
            tap[j] = (int'(row) >= j) ? lbuf[j-1][col] : '0;
        end
    end

    // Stage 1: per-tap signed products.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < K; j++) begin
                prod[j] <= PW'(signed'(coef_eff[j*CW +: CW])) * PW'(signed'({1'b0, tap[j]}));
            end
        end
    end

    // Stage 2 datapath: sum, round half up, arithmetic shift, clamp.
    always_comb begin
        acc = '0;
        for (int j = 0; j < K; j++) begin
            acc = acc + AW'(prod[j]);
        end
        res = (acc + RND) >>> SHIFT;
        if (res < 0) begin
            sat = '0;
        end else if (res > MAXV) begin
            sat = '1;
        end else begin
            sat = res[DW-1:0];
        end
    end

    // Valid bits advance every cycle so results drain during input stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1         <= 1'b0;
            fd1        <= 1'b0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            pxl_out    <= '0;
        end else begin
            v1         <= accept && emit;
            fd1        <= accept && frame_last;
            valid      <= v1;
            frame_done <= fd1;
            if (v1) begin
                pxl_out <= sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_kx1_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_conv_kx1_stream
// Description : Scoreboard bench for conv_kx1_stream on a reduced frame size.
//               The driver computes each expected output from a frame image
//               with plain arithmetic and queues it; a negedge monitor pops
//               and compares value, frame_done and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_kx1_stream;
    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int K     = 7;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int SHIFT = 6;
    localparam int FRAME = IMG_W * IMG_H;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   pxl_in;
    logic            pxl_in_vld;
    logic [K*CW-1:0] coef;
    logic            pad_mode;
    logic [DW-1:0]   pxl_out;
    logic            valid;
    logic            frame_done;

    always #5 clk = ~clk;

    conv_kx1_stream #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW), .CW(CW), .SHIFT(SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pxl_in     (pxl_in),
        .pxl_in_vld (pxl_in_vld),
        .coef       (coef),
        .pad_mode   (pad_mode),
        .pxl_out    (pxl_out),
        .valid      (valid),
        .frame_done (frame_done)
    );

    typedef struct {
        int val;
        bit last;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   fd_exp  = 0;
    int   fd_seen = 0;
    int   img [IMG_H][IMG_W];
    int   fcoef [K];
    int   ncoef [K];
    bit   fpad, npad;
    int   mr = 0, mc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: direct sum over the frame image, top-border rows read as 0.
    function automatic int model(input int r, input int c);
        int acc = 0;
        int res;
        for (int j = 0; j < K; j++) begin
            if (r - j >= 0) acc += fcoef[j] * img[r-j][c];
        end
        res = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
        if (res < 0) return 0;
        if (res > (1 << DW) - 1) return (1 << DW) - 1;
        return res;
    endfunction

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (frame_done === 1'b1) fd_seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 pxl_out=%0d, expected no output (cycle %0d)", pxl_out, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("pxl_out", 32'(pxl_out), mon_e.val);
                chk("frame_done", 32'(frame_done), 32'(mon_e.last));
                chk("latency", cyc, mon_e.due);
            end
        end else begin
            chk("idle_frame_done", 32'(frame_done), 0);
        end
    end

    task automatic junk_cfg(input bit junk);
        if (junk && !(mr == 0 && mc == 0)) begin
            for (int j = 0; j < K; j++) coef[j*CW +: CW] = CW'($urandom);
            pad_mode = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_px(input int p, input bit stall, input bit junk);
        exp_t e;
        while (stall && $urandom_range(0, 1) == 0) begin
            @(posedge clk); #1;
            pxl_in_vld = 1'b0;
            pxl_in     = DW'($urandom);
            junk_cfg(junk);
        end
        @(posedge clk); #1;
        if (mr == 0 && mc == 0) begin
            fcoef = ncoef;
            fpad  = npad;
            for (int j = 0; j < K; j++) coef[j*CW +: CW] = CW'(ncoef[j]);
            pad_mode = npad;
        end else begin
            junk_cfg(junk);
        end
        pxl_in     = DW'(p);
        pxl_in_vld = 1'b1;
        img[mr][mc] = p;
        if (fpad || mr >= K - 1) begin
            e.val  = model(mr, mc);
            e.last = (mr == IMG_H - 1) && (mc == IMG_W - 1);
            e.due  = cyc + 2;
            q.push_back(e);
            if (e.last) fd_exp++;
        end
        if (mc == IMG_W - 1) begin
            mc = 0;
            mr = (mr == IMG_H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    // kind: 0 identity ramp (n mod 256), 1 constant cval, 2 random pixels.
    task automatic send_frame(input int kind, input int cval, input bit stall,
                              input bit junk, input int npx);
        int p;
        for (int n = 0; n < npx; n++) begin
            case (kind)
                0:       p = (mr * IMG_W + mc) % 256;
                1:       p = cval;
                default: p = int'($urandom_range(0, 255));
            endcase
            send_px(p, stall, junk);
        end
    endtask

    task automatic set_all(input int v);
        for (int j = 0; j < K; j++) ncoef[j] = v;
    endtask

    task automatic set_tap0(input int v);
        for (int j = 0; j < K; j++) ncoef[j] = 0;
        ncoef[0] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            pxl_in_vld = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_pxl_out"}, 32'(pxl_out), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        pxl_in_vld = 1'b0;
        pxl_in     = '0;
        coef       = '0;
        pad_mode   = 1'b0;
        npad       = 1'b0;
        set_tap0(64);
        repeat (3) @(posedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;

        // Identity, box, both saturation directions.
        set_tap0(64);  npad = 1'b0; send_frame(0, 0,   1'b0, 1'b0, FRAME);
        set_all(9);    npad = 1'b0; send_frame(1, 100, 1'b0, 1'b0, FRAME);
        set_tap0(127);              send_frame(1, 255, 1'b0, 1'b0, FRAME);
        set_tap0(-64);              send_frame(1, 255, 1'b0, 1'b0, FRAME);

        // Zero-padded top border, two frames back to back.
        set_all(9);    npad = 1'b1; send_frame(1, 100, 1'b0, 1'b0, 2 * FRAME);

        // Stalled input.
        set_tap0(64);  npad = 1'b0; send_frame(0, 0,   1'b1, 1'b0, FRAME);
        set_all(9);    npad = 1'b0; send_frame(1, 100, 1'b1, 1'b0, FRAME);
        idle(4);

        // Random images/coefficients, mid-frame config churn.
        repeat (6) begin
            for (int j = 0; j < K; j++) ncoef[j] = int'($urandom_range(0, 255)) - 128;
            npad = 1'($urandom_range(0, 1));
            send_frame(2, 0, 1'($urandom_range(0, 1)), 1'b1, FRAME);
        end

        // Reset in the middle of a frame with results in flight.
        set_tap0(64); npad = 1'b0;
        send_frame(0, 0, 1'b0, 1'b0, 150);
        @(posedge clk); #1;
        reset      = 1'b0;
        pxl_in_vld = 1'b0;
        q.delete();
        mr = 0;
        mc = 0;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        send_frame(0, 0, 1'b0, 1'b0, FRAME);
        idle(6);

        chk("queue_drained", q.size(), 0);
        chk("frame_done_count", fd_seen, fd_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
